fft_input_commutator: RTL and testbench

FFT_INPUT_COMMUTATOR -- requirements
Module: fft_input_commutator

---
 rtl/fft_input_commutator.sv | 104 ++++++++++
 tb/tb_fft_input_commutator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_commutator.sv
// Radix-2 SDF input commutator: delay line on the b path, swap, delay line on line 1.
// Select comes from the accepted-sample frame counter; bypass passes samples straight through.
module fft_input_commutator #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] din_a,
  input  logic signed [WIDTH-1:0] din_b,
  input  logic                    in_valid,
  input  logic                    sync,
  input  logic                    bypass,
  output logic signed [WIDTH-1:0] out1,
  output logic signed [WIDTH-1:0] out2,
  output logic                    out_valid
);

  localparam int KW = $clog2(2 * DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic signed [WIDTH-1:0] smp_t;

  smp_t          bline [DEPTH];
  smp_t          lline [DEPTH];
  logic [KW-1:0] k;
  logic [KW-1:0] kcur;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ccur;
  logic          take;
  logic          sel;
  logic          primed;
  smp_t          bd;
  smp_t          ld;
  smp_t          line1;
  smp_t          line2;

  // sync restarts both the frame index and the priming count on its own sample
  always_comb begin
    take   = in_valid & ~bypass;
    kcur   = sync ? '0 : k;
    ccur   = sync ? '0 : cnt;
    primed = (ccur == CW'(DEPTH));
    sel    = kcur[KW-1];
    bd     = bline[DEPTH-1];
    ld     = lline[DEPTH-1];
    line1  = sel ? bd : din_a;
    line2  = sel ? din_a : bd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bline[i] <= '0;
        lline[i] <= '0;
      end
    end else if (take) begin
      bline[0] <= din_b;
      lline[0] <= line1;
      for (int i = 1; i < DEPTH; i++) begin
        bline[i] <= bline[i-1];
        lline[i] <= lline[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else if (take) begin
      k <= kcur + KW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bypass) begin
      cnt <= '0;
    end else if (in_valid) begin
      cnt <= primed ? ccur : ccur + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1      <= '0;
      out2      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid & (bypass | primed);
      if (in_valid) begin
        if (bypass) begin
          out1 <= din_a;
          out2 <= din_b;
        end else begin
          out1 <= ld;
          out2 <= line2;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_input_commutator.sv
// Bench for fft_input_commutator: directed streams plus random traffic
// against a history-queue reference model.
module tb_fft_input_commutator;

  localparam int W = 12;
  localparam int D = 4;

  logic                clk;
  logic                rst_n;
  logic signed [W-1:0] din_a;
  logic signed [W-1:0] din_b;
  logic                in_valid;
  logic                sync;
  logic                bypass;
  logic signed [W-1:0] out1;
  logic signed [W-1:0] out2;
  logic                out_valid;

  int total;
  int bad;

  int bh[$];
  int lh[$];
  int mk;
  int mcnt;
  int e1;
  int e2;
  int ev;

  fft_input_commutator #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_a    (din_a),
    .din_b    (din_b),
    .in_valid (in_valid),
    .sync     (sync),
    .bypass   (bypass),
    .out1     (out1),
    .out2     (out2),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    bh.delete();
    lh.delete();
    for (int i = 0; i < D; i++) begin
      bh.push_back(0);
      lh.push_back(0);
    end
    mk   = 0;
    mcnt = 0;
    e1   = 0;
    e2   = 0;
    ev   = 0;
  endtask

  // Sample n of the accepted stream has frame index kk; bd/ld are the
  // values accepted D samples ago, kept as plain history queues.
  task automatic model_step(input int a, input int b, input bit v,
                            input bit s, input bit byp);
    int kk;
    int bdv;
    int ldv;
    int l1;
    int l2;
    if (byp) mcnt = 0;
    if (!v) begin
      ev = 0;
    end else if (byp) begin
      e1 = a;
      e2 = b;
      ev = 1;
    end else begin
      kk = s ? 0 : mk;
      if (s) mcnt = 0;
      ev  = (mcnt == D) ? 1 : 0;
      bdv = bh[bh.size() - D];
      ldv = lh[lh.size() - D];
      l1  = (kk >= D) ? bdv : a;
      l2  = (kk >= D) ? a : bdv;
      bh.push_back(b);
      lh.push_back(l1);
      void'(bh.pop_front());
      void'(lh.pop_front());
      e1 = ldv;
      e2 = l2;
      mk = (kk + 1) % (2 * D);
      if (mcnt < D) mcnt++;
    end
  endtask

  task automatic step(input int a, input int b, input bit v,
                      input bit s, input bit byp);
    din_a    = W'(a);
    din_b    = W'(b);
    in_valid = v;
    sync     = s;
    bypass   = byp;
    @(posedge clk);
    #1;
    model_step(a, b, v, s, byp);
    chk("out_valid", int'(out_valid), ev);
    chk("out1", int'(out1), e1);
    chk("out2", int'(out2), e2);
  endtask

  // Reset asserted between edges; outputs must clear before any clock.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out1", int'(out1), 0);
    chk("rst_out2", int'(out2), 0);
    chk("rst_valid", int'(out_valid), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    din_a    = '0;
    din_b    = '0;
    in_valid = 1'b0;
    sync     = 1'b0;
    bypass   = 1'b0;
    rst_n    = 1'b1;
    #2;
    pulse_reset();

    for (int n = 0; n < 12; n++) begin
      step(n, 100 + n, 1'b1, n == 0, 1'b0);
      if (n == 3) chk("v_before_prime", int'(out_valid), 0);
      if (n == 4) begin
        chk("n4_o1", int'(out1), 0);
        chk("n4_o2", int'(out2), 4);
        chk("n4_v", int'(out_valid), 1);
      end
      if (n == 8) begin
        chk("n8_o1", int'(out1), 100);
        chk("n8_o2", int'(out2), 104);
      end
      if (n == 11) begin
        chk("n11_o1", int'(out1), 103);
        chk("n11_o2", int'(out2), 107);
      end
    end

    pulse_reset();
    for (int n = 0; n < 10; n++) begin
      step(n, 100 + n, 1'b1, n == 0, 1'b0);
      if (n == 5) begin
        for (int g = 0; g < 3; g++) step(0, 0, 1'b0, 1'b0, 1'b0);
        chk("gap_o1", int'(out1), 1);
        chk("gap_o2", int'(out2), 5);
        chk("gap_v", int'(out_valid), 0);
      end
      if (n == 6) begin
        chk("resume_o1", int'(out1), 2);
        chk("resume_o2", int'(out2), 6);
      end
    end

    pulse_reset();
    for (int n = 0; n < 14; n++) begin
      step(n, 100 + n, 1'b1, n == 0 || n == 6, 1'b0);
      if (n == 9) chk("resync_v9", int'(out_valid), 0);
      if (n == 10) begin
        chk("resync_o1", int'(out1), 6);
        chk("resync_o2", int'(out2), 10);
        chk("resync_v", int'(out_valid), 1);
      end
    end

    pulse_reset();
    for (int n = 0; n < 12; n++) begin
      step(n, 100 + n, 1'b1, n == 0, n >= 3 && n <= 5);
      if (n == 4) begin
        chk("byp_o1", int'(out1), 4);
        chk("byp_o2", int'(out2), 104);
        chk("byp_v", int'(out_valid), 1);
      end
      if (n == 9) chk("post_byp_v", int'(out_valid), 0);
      if (n == 10) chk("post_byp_v10", int'(out_valid), 1);
    end

    for (int n = 0; n < 9; n++) step(n, 100 + n, 1'b1, n == 0, 1'b0);
    pulse_reset();
    for (int n = 0; n < 8; n++) begin
      step(-2048 + n, -2000 + n, 1'b1, 1'b0, 1'b0);
      if (n == 4) begin
        chk("neg_o1", int'(out1), -2048);
        chk("neg_o2", int'(out2), -2044);
        chk("neg_v", int'(out_valid), 1);
      end
    end

    for (int c = 0; c < 3000; c++) begin
      int  a;
      int  b;
      bit  byp;
      a   = int'($urandom_range(4095)) - 2048;
      b   = int'($urandom_range(4095)) - 2048;
      byp = ($urandom_range(24) == 0);
      step(a, b, $urandom_range(3) != 0,
           !byp && ($urandom_range(15) == 0), byp);
      if (c == 1500) pulse_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
